// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_loader
// Description : Streams bytes into inst_mem as INSTR_W-bit words, verifies a
//               trailing XOR checksum and holds the core until a clean load.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_loader #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W:0]    words_loaded
);

    localparam int               c_BPW       = INSTR_W / 8;
    localparam int               c_BCW       = (c_BPW > 1) ? $clog2(c_BPW) : 1;
    localparam logic [c_BCW-1:0] c_LAST_BYTE = c_BCW'(c_BPW - 1);
    localparam logic [8:0]       c_DEPTH     = 9'(1 << ADDR_W);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LEN  = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
    localparam logic [2:0] c_CSUM = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0]         r_state;
    logic [c_BCW-1:0]   r_byteCnt;
    logic [ADDR_W-1:0]  r_wordIdx;
    logic [ADDR_W-1:0]  r_lastIdx;
    logic [7:0]         r_csum;
    logic               w_accept;
    logic               w_shiftEn;
    logic               w_lenBad;
    logic [INSTR_W-1:0] w_asmNext;

    assign in_ready  = (r_state == c_LEN) || (r_state == c_DATA) || (r_state == c_CSUM);
    assign w_accept  = in_valid && in_ready;
    assign w_shiftEn = w_accept && (r_state == c_DATA);
    assign w_lenBad  = ({1'b0, in_data} >= c_DEPTH);

    // Only the earlier bytes of a word are stored; the newest byte comes straight from the bus.
    generate
        if (INSTR_W > 8) begin : g_wide
            logic [INSTR_W-9:0] r_asm;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_asm <= '0;
                end else if (w_shiftEn) begin
                    r_asm <= w_asmNext[INSTR_W-9:0];
                end
            end
            assign w_asmNext = {r_asm, in_data};
        end else begin : g_narrow
            assign w_asmNext = in_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_byteCnt    <= '0;
            r_wordIdx    <= '0;
            r_lastIdx    <= '0;
            r_csum       <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state      <= c_LEN;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        cpu_hold     <= 1'b1;
                        words_loaded <= '0;
                    end
                end
                c_LEN: begin
                    if (w_accept) begin
                        if (w_lenBad) begin
                            r_state <= c_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            r_state   <= c_DATA;
                            r_lastIdx <= in_data[ADDR_W-1:0];
                            r_csum    <= '0;
                            r_byteCnt <= '0;
                            r_wordIdx <= '0;
                        end
                    end
                end
                c_DATA: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ in_data;
                        if (r_byteCnt == c_LAST_BYTE) begin
                            // Write strobe lands one cycle after the word's last byte.
                            r_byteCnt    <= '0;
                            imem_we      <= 1'b1;
                            imem_addr    <= r_wordIdx;
                            imem_wdata   <= w_asmNext;
                            words_loaded <= words_loaded + 1'b1;
                            r_wordIdx    <= r_wordIdx + 1'b1;
                            if (r_wordIdx == r_lastIdx) begin
                                r_state <= c_CSUM;
                            end
                        end else begin
                            r_byteCnt <= r_byteCnt + 1'b1;
                        end
                    end
                end
                c_CSUM: begin
                    if (w_accept) begin
                        r_state  <= c_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        err      <= (in_data != r_csum);
                        cpu_hold <= (in_data != r_csum);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_loader
// Description : Randomized self-checking bench for inst_loader against a
//               stream-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

    localparam int IW  = 16;
    localparam int AW  = 8;
    localparam int BPW = IW / 8;

    typedef logic [7:0] byteQ_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, imem_we, cpu_hold, busy, done, err;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;
    logic [AW:0]   words_loaded;

    logic          start4 = 1'b0;
    logic          in_valid4 = 1'b0;
    logic [7:0]    in_data4 = 8'h00;
    logic          in_ready4, imem_we4, cpu_hold4, busy4, done4, err4;
    logic [3:0]    imem_addr4;
    logic [IW-1:0] imem_wdata4;
    logic [4:0]    words_loaded4;

    int total = 0;
    int bad   = 0;

    logic          monOn = 1'b0;
    logic          weExp = 1'b0;
    logic [AW-1:0] addrExp = '0;
    logic [IW-1:0] dataExp = '0;

    inst_loader #(.INSTR_W(IW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
    );

    inst_loader #(.INSTR_W(IW), .ADDR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
        .cpu_hold(cpu_hold4), .busy(busy4), .done(done4), .err(err4), .words_loaded(words_loaded4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write-port scoreboard: every cycle the strobe must match the model exactly.
    always @(negedge clk) begin
        if (monOn) begin
            chk("imem_we", imem_we, weExp);
            if (weExp) begin
                chk("imem_addr", imem_addr, addrExp);
                chk("imem_wdata", imem_wdata, dataExp);
                chk("words_at_write", words_loaded, addrExp + 1);
            end
            chk("imem_we4", imem_we4, 1'b0);
        end
    end

    task automatic checkIdleOutputs(input string tag);
        chk({tag, "_ready"}, in_ready, 1'b0);
        chk({tag, "_hold"},  cpu_hold, 1'b1);
        chk({tag, "_busy"},  busy, 1'b0);
        chk({tag, "_done"},  done, 1'b0);
        chk({tag, "_err"},   err, 1'b0);
        chk({tag, "_words"}, words_loaded, 0);
        chk({tag, "_addr"},  imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
    endtask

    function automatic byteQ_t makeStream(input int l, input bit corrupt);
        byteQ_t q;
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        q.push_back(8'(l));
        for (int i = 0; i < (l + 1) * BPW; i++) begin
            b = 8'($urandom);
            cs ^= b;
            q.push_back(b);
        end
        if (corrupt) cs ^= 8'(1 << $urandom_range(0, 7));
        q.push_back(cs);
        return q;
    endfunction

    // mode: 0 back-to-back, 1 alternate valid, 2 random gaps. abortAfter<0 disables reset abort.
    task automatic runLoad(input byteQ_t s, input int mode, input int abortAfter, input bit startNoise);
        int         n, consume, idx, cyc;
        bit         lenBad, expErr, offer, pend;
        logic [7:0] cs;
        logic [IW-1:0] word;
        logic [AW-1:0] pAddr;
        n       = int'(s[0]) + 1;
        lenBad  = int'(s[0]) >= (1 << AW);
        consume = lenBad ? 1 : 2 + n * BPW;
        expErr  = lenBad;
        cs = 8'h00; word = '0; pend = 1'b0; pAddr = '0; idx = 0; cyc = 0;

        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1'b1);
        chk("start_done", done, 1'b0);
        chk("start_err", err, 1'b0);
        chk("start_words", words_loaded, 0);
        chk("start_hold", cpu_hold, 1'b1);

        while (idx < consume) begin
            @(posedge clk); #1;
            weExp = pend;
            pend  = 1'b0;
            if (idx == abortAfter) begin
                rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1; weExp = 1'b0;
                @(negedge clk);
                checkIdleOutputs("abort");
                return;
            end
            cyc++;
            if (cyc > 4 * consume + 50) begin
                chk("load_timeout", 1, 0);
                return;
            end
            start = startNoise && ($urandom_range(0, 3) == 0);
            case (mode)
                0:       offer = 1'b1;
                1:       offer = cyc[0];
                default: offer = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = offer;
            in_data  = offer ? s[idx] : 8'($urandom);
            @(negedge clk);
            chk("ready_in_load", in_ready, 1'b1);
            chk("busy_in_load", busy, 1'b1);
            if (offer) begin
                if (idx == consume - 1 && !lenBad) begin
                    expErr = (s[idx] != cs);
                end else if (idx > 0) begin
                    cs   ^= s[idx];
                    word  = {word[IW-9:0], s[idx]};
                    if (idx % BPW == 0) begin
                        pend    = 1'b1;
                        pAddr   = AW'(idx / BPW - 1);
                        addrExp = pAddr;
                        dataExp = word;
                    end
                end
                idx++;
            end
        end
        @(posedge clk); #1;
        weExp = pend; in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("end_done", done, 1'b1);
        chk("end_busy", busy, 1'b0);
        chk("end_ready", in_ready, 1'b0);
        chk("end_err", err, expErr);
        chk("end_hold", cpu_hold, expErr);
        chk("end_words", words_loaded, lenBad ? 0 : n);
        @(posedge clk); #1;
        weExp = 1'b0;
    endtask

    task automatic offerWhileParked(input string tag, input bit expDone);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = 8'hA5;
            @(negedge clk);
            chk({tag, "_ready"}, in_ready, 1'b0);
            chk({tag, "_done"}, done, expDone);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    byteQ_t s1;

    initial begin
        s1 = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h2E};
        repeat (2) @(posedge clk);
        @(negedge clk);
        monOn = 1'b1;
        checkIdleOutputs("reset");
        chk("reset_done4", done4, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        offerWhileParked("idle_offer", 1'b0);
        runLoad(s1, 0, -1, 1'b0);
        chk("clean_hold", cpu_hold, 1'b0);
        offerWhileParked("done_offer", 1'b1);

        s1[7] = 8'h2F;
        runLoad(s1, 0, -1, 1'b0);
        s1[7] = 8'h2E;
        runLoad(s1, 1, -1, 1'b0);
        runLoad(s1, 2, -1, 1'b1);

        runLoad(s1, 0, 4, 1'b0);
        runLoad(s1, 0, -1, 1'b0);

        // Narrow-address instance: header 0x10 exceeds 16 words.
        @(posedge clk); #1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; in_valid4 = 1'b1; in_data4 = 8'h10;
        @(negedge clk);
        chk("len4_ready", in_ready4, 1'b1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(negedge clk);
        chk("len4_done", done4, 1'b1);
        chk("len4_err", err4, 1'b1);
        chk("len4_hold", cpu_hold4, 1'b1);
        chk("len4_words", words_loaded4, 0);

        runLoad(makeStream(255, 1'b0), 2, -1, 1'b1);

        for (int t = 0; t < 20; t++) begin
            runLoad(makeStream($urandom_range(0, 15), ($urandom_range(0, 1) == 1)),
                    $urandom_range(0, 2), -1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
